// File: rtl/nice_reg_bridge_if.sv
// NICE accelerator command/response channel between the E203 core (master)
// and the register bridge (slave).
interface nice_reg_bridge_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              nice_acr_cmd_valid;
    logic              nice_acr_cmd_ready;
    logic [ADDR_W-1:0] nice_acr_cmd_addr;
    logic              nice_acr_cmd_read;
    logic [DATA_W-1:0] nice_acr_cmd_wdata;
    logic              nice_acr_rsp_valid;
    logic              nice_acr_rsp_ready;
    logic [DATA_W-1:0] nice_acr_rsp_rdata;
    logic              nice_acr_rsp_err;

    modport master (
        output nice_acr_cmd_valid, nice_acr_cmd_addr, nice_acr_cmd_read,
               nice_acr_cmd_wdata, nice_acr_rsp_ready,
        input  nice_acr_cmd_ready, nice_acr_rsp_valid, nice_acr_rsp_rdata,
               nice_acr_rsp_err
    );

    modport slave (
        input  nice_acr_cmd_valid, nice_acr_cmd_addr, nice_acr_cmd_read,
               nice_acr_cmd_wdata, nice_acr_rsp_ready,
        output nice_acr_cmd_ready, nice_acr_rsp_valid, nice_acr_rsp_rdata,
               nice_acr_rsp_err
    );
endinterface

// File: rtl/nice_reg_bridge.sv
// Bridge from the NICE command port to NUM_CH address-ranged write channels
// and a fixed-latency shared read port, with per-write timeout and error count.
module nice_reg_bridge #(
    parameter int                       ADDR_W  = 6,
    parameter int                       DATA_W  = 32,
    parameter int                       NUM_CH  = 2,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_LO   = {6'd30, 6'd21},
    parameter logic [NUM_CH*ADDR_W-1:0] CH_HI   = {6'd39, 6'd29},
    parameter int                       RD_LAT  = 1,
    parameter int                       TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    nice_reg_bridge_if.slave    nice,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_CH-1:0]   wr_valid,
    input  logic [NUM_CH-1:0]   wr_ready,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_en,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [7:0]          err_cnt
);

    localparam int CNT_MAX = (RD_LAT > TIMEOUT) ? RD_LAT : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_WR,
        S_RD,
        S_RSP
    } state_t;

    state_t              r_state;
    logic                r_cmd_ready;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_read;
    logic [DATA_W-1:0]   r_wdata;
    logic [NUM_CH-1:0]   r_wr_valid;
    logic                r_rd_en;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic [7:0]          r_err_cnt;

    logic                w_hit;
    logic [NUM_CH-1:0]   w_onehot;
    logic                w_wr_done;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Scan from the top so the lowest matching channel wins.
    always_comb begin
        w_hit    = 1'b0;
        w_onehot = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if ((r_addr >= CH_LO[i*ADDR_W +: ADDR_W]) &&
                (r_addr <= CH_HI[i*ADDR_W +: ADDR_W])) begin
                w_hit       = 1'b1;
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_wr_done = |(r_wr_valid & wr_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_addr      <= '0;
            r_read      <= 1'b0;
            r_wdata     <= '0;
            r_wr_valid  <= '0;
            r_rd_en     <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && nice.nice_acr_cmd_valid) begin
                        r_addr      <= nice.nice_acr_cmd_addr;
                        r_read      <= nice.nice_acr_cmd_read;
                        r_wdata     <= nice.nice_acr_cmd_wdata;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_DEC;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_DEC: begin
                    r_cnt <= '0;
                    if (r_read) begin
                        r_rd_en <= 1'b1;
                        r_state <= S_RD;
                    end else if (w_hit) begin
                        r_wr_valid <= w_onehot;
                        r_state    <= S_WR;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_err_cnt   <= sat_inc(r_err_cnt);
                        r_state     <= S_RSP;
                    end
                end
                S_WR: begin
                    if (w_wr_done) begin
                        r_wr_valid  <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RSP;
                    end else if ((TIMEOUT != 0) && (r_cnt == CNT_W'(TO_LAST))) begin
                        r_wr_valid  <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_err_cnt   <= sat_inc(r_err_cnt);
                        r_state     <= S_RSP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RD: begin
                    // r_cnt counts cycles since the rd_en pulse; the RAM word is valid at RD_LAT.
                    if (r_cnt == CNT_W'(RD_LAT)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= rd_data;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RSP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RSP: begin
                    if (nice.nice_acr_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign nice.nice_acr_cmd_ready = r_cmd_ready;
    assign nice.nice_acr_rsp_valid = r_rsp_valid;
    assign nice.nice_acr_rsp_rdata = r_rsp_rdata;
    assign nice.nice_acr_rsp_err   = r_rsp_err;
    assign wr_addr  = r_addr;
    assign wr_data  = r_wdata;
    assign wr_valid = r_wr_valid;
    assign rd_addr  = r_addr;
    assign rd_en    = r_rd_en;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_nice_reg_bridge.sv
// Directed bench for nice_reg_bridge: a vector table for single transactions
// plus hand sequences for stalls, back-to-back commands, RD_LAT=3 and reset.
module tb_nice_reg_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_ready;
    logic [31:0] rd_data;
    logic [5:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_valid;
    logic        rd_en;
    logic [7:0]  err_cnt;

    logic [5:0]  wr_addr3, rd_addr3;
    logic [31:0] wr_data3;
    logic [1:0]  wr_valid3;
    logic        rd_en3;
    logic [7:0]  err_cnt3;

    int n_pass = 0;
    int n_tot  = 0;
    int exp_errcnt = 0;

    always #5 clk = ~clk;

    nice_reg_bridge_if #(.ADDR_W(6), .DATA_W(32)) ifc ();
    nice_reg_bridge_if #(.ADDR_W(6), .DATA_W(32)) ifc3 ();

    nice_reg_bridge u_dut (
        .clk(clk), .rst(rst), .nice(ifc),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .err_cnt(err_cnt)
    );

    nice_reg_bridge #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .nice(ifc3),
        .wr_addr(wr_addr3), .wr_data(wr_data3), .wr_valid(wr_valid3), .wr_ready(2'b00),
        .rd_addr(rd_addr3), .rd_en(rd_en3), .rd_data(rd_data), .err_cnt(err_cnt3)
    );

    typedef struct {
        logic [5:0]  addr;
        logic        rd;
        logic [31:0] wdata;
        logic [31:0] rdval;
        logic [1:0]  rdy;
        logic [1:0]  exp_wv;
        int          exp_wv_cyc;
        int          exp_wv_cnt;
        int          exp_rden;
        int          exp_rsp_cyc;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Waits for cmd_ready, presents one command for one edge; returns in cycle 1.
    task automatic send(input logic [5:0] a, input logic rd, input logic [31:0] wd);
        int t = 0;
        while (ifc.nice_acr_cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_wait", 32'(ifc.nice_acr_cmd_ready), 32'd1);
        ifc.nice_acr_cmd_valid = 1'b1;
        ifc.nice_acr_cmd_addr  = a;
        ifc.nice_acr_cmd_read  = rd;
        ifc.nice_acr_cmd_wdata = wd;
        @(negedge clk);
        ifc.nice_acr_cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 1, wv_cyc = 0, wv_cnt = 0, rden_cnt = 0, rsp_cyc = 0, bad = 0;
        logic [1:0]  wv_val = 2'b00;
        logic [31:0] rdata = '0;
        logic        err = 1'b0;
        string       tag;
        tag = $sformatf("v%0d", idx);
        wr_ready = v.rdy;
        rd_data  = v.rdval;
        ifc.nice_acr_rsp_ready = 1'b1;
        send(v.addr, v.rd, v.wdata);
        while (rsp_cyc == 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (wr_valid != 2'b00) begin
                if (wv_cnt == 0) begin
                    wv_val = wr_valid;
                    wv_cyc = cyc;
                end
                wv_cnt++;
                if (wr_data !== v.wdata || wr_addr !== v.addr || wr_valid !== v.exp_wv) bad++;
            end
            if (rd_en) begin
                rden_cnt++;
                if (rd_addr !== v.addr || cyc != 2) bad++;
            end
            if (ifc.nice_acr_rsp_valid) begin
                rsp_cyc = cyc;
                rdata   = ifc.nice_acr_rsp_rdata;
                err     = ifc.nice_acr_rsp_err;
                chk({tag, "_errcnt"}, 32'(err_cnt), 32'(exp_errcnt + (v.exp_err ? 1 : 0)));
            end
        end
        if (v.exp_err) exp_errcnt++;
        chk({tag, "_wv"}, 32'(wv_val), 32'(v.exp_wv));
        chk({tag, "_wv_cyc"}, 32'(wv_cyc), 32'(v.exp_wv_cyc));
        chk({tag, "_wv_cnt"}, 32'(wv_cnt), 32'(v.exp_wv_cnt));
        chk({tag, "_stable"}, 32'(bad), 32'd0);
        chk({tag, "_rden"}, 32'(rden_cnt), 32'(v.exp_rden));
        chk({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'(v.exp_rsp_cyc));
        chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
        chk({tag, "_rdata"}, rdata, v.exp_rdata);
        @(negedge clk);
        chk({tag, "_b2b_ready"}, 32'(ifc.nice_acr_cmd_ready), 32'd1);
        chk({tag, "_rsp_drop"}, 32'(ifc.nice_acr_rsp_valid), 32'd0);
        wr_ready = 2'b00;
    endtask

    initial begin
        int wv_cnt, rsp_cyc, rden_cnt, bad;

        vecs[0] = '{6'd25, 1'b0, 32'hDEADBEEF, 32'h0,        2'b01, 2'b01, 2, 1,  0, 3,  1'b0, 32'h0};
        vecs[1] = '{6'd50, 1'b0, 32'h11111111, 32'h0,        2'b11, 2'b00, 0, 0,  0, 2,  1'b1, 32'h0};
        vecs[2] = '{6'd21, 1'b0, 32'h22222222, 32'h0,        2'b00, 2'b01, 2, 16, 0, 18, 1'b1, 32'h0};
        vecs[3] = '{6'd7,  1'b1, 32'h0,        32'h12345678, 2'b00, 2'b00, 0, 0,  1, 4,  1'b0, 32'h12345678};
        vecs[4] = '{6'd39, 1'b0, 32'h39393939, 32'h0,        2'b10, 2'b10, 2, 1,  0, 3,  1'b0, 32'h0};
        vecs[5] = '{6'd30, 1'b0, 32'h30303030, 32'h0,        2'b01, 2'b10, 2, 16, 0, 18, 1'b1, 32'h0};
        vecs[6] = '{6'd20, 1'b0, 32'h20202020, 32'h0,        2'b11, 2'b00, 0, 0,  0, 2,  1'b1, 32'h0};
        vecs[7] = '{6'd29, 1'b0, 32'h29292929, 32'h0,        2'b01, 2'b01, 2, 1,  0, 3,  1'b0, 32'h0};
        vecs[8] = '{6'd63, 1'b1, 32'h0,        32'hA5A55A5A, 2'b00, 2'b00, 0, 0,  1, 4,  1'b0, 32'hA5A55A5A};

        rst = 1'b1;
        wr_ready = 2'b00;
        rd_data  = 32'h0;
        ifc.nice_acr_cmd_valid = 1'b0;
        ifc.nice_acr_cmd_addr  = '0;
        ifc.nice_acr_cmd_read  = 1'b0;
        ifc.nice_acr_cmd_wdata = '0;
        ifc.nice_acr_rsp_ready = 1'b1;
        ifc3.nice_acr_cmd_valid = 1'b0;
        ifc3.nice_acr_cmd_addr  = '0;
        ifc3.nice_acr_cmd_read  = 1'b0;
        ifc3.nice_acr_cmd_wdata = '0;
        ifc3.nice_acr_rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(ifc.nice_acr_cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(ifc.nice_acr_rsp_valid), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_rdata", ifc.nice_acr_rsp_rdata, 32'd0);
        rst = 1'b0;
        chk("rel_cmd_ready_low", 32'(ifc.nice_acr_cmd_ready), 32'd0);
        @(negedge clk);
        chk("rel_cmd_ready_high", 32'(ifc.nice_acr_cmd_ready), 32'd1);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Channel 1 stalls for 5 cycles: wr_valid must hold for 6 with stable data.
        wr_ready = 2'b00;
        send(6'd35, 1'b0, 32'h0BADF00D);
        wv_cnt = 0; rsp_cyc = 0; bad = 0;
        for (int c = 2; c < 30 && rsp_cyc == 0; c++) begin
            @(negedge clk);
            if (wr_valid != 2'b00) begin
                wv_cnt++;
                if (wr_valid !== 2'b10 || wr_data !== 32'h0BADF00D || wr_addr !== 6'd35) bad++;
            end
            if (ifc.nice_acr_rsp_valid) begin
                rsp_cyc = c;
                chk("stall_err", 32'(ifc.nice_acr_rsp_err), 32'd0);
            end
            if (c == 7) wr_ready = 2'b10;
        end
        chk("stall_wv_cnt", 32'(wv_cnt), 32'd6);
        chk("stall_stable", 32'(bad), 32'd0);
        chk("stall_rsp_cyc", 32'(rsp_cyc), 32'd8);
        @(negedge clk);
        wr_ready = 2'b00;

        // Response back-pressure with a second command waiting.
        wr_ready = 2'b01;
        ifc.nice_acr_rsp_ready = 1'b0;
        chk("bp_ready0", 32'(ifc.nice_acr_cmd_ready), 32'd1);
        ifc.nice_acr_cmd_valid = 1'b1;
        ifc.nice_acr_cmd_addr  = 6'd25;
        ifc.nice_acr_cmd_read  = 1'b0;
        ifc.nice_acr_cmd_wdata = 32'hCAFEF00D;
        @(negedge clk);
        ifc.nice_acr_cmd_addr  = 6'd50;
        @(negedge clk);
        chk("bp_wv", 32'(wr_valid), 32'd1);
        bad = 0;
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            if (ifc.nice_acr_rsp_valid !== 1'b1 || ifc.nice_acr_rsp_err !== 1'b0 ||
                ifc.nice_acr_rsp_rdata !== 32'h0 || ifc.nice_acr_cmd_ready !== 1'b0) bad++;
        end
        chk("bp_hold", 32'(bad), 32'd0);
        @(negedge clk);
        chk("bp_still_valid", 32'(ifc.nice_acr_rsp_valid), 32'd1);
        ifc.nice_acr_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_b2b_ready", 32'(ifc.nice_acr_cmd_ready), 32'd1);
        chk("bp_rsp_done", 32'(ifc.nice_acr_rsp_valid), 32'd0);
        @(negedge clk);
        chk("bp_accept2", 32'(ifc.nice_acr_cmd_ready), 32'd0);
        ifc.nice_acr_cmd_valid = 1'b0;
        @(negedge clk);
        exp_errcnt++;
        chk("bp_rsp2_valid", 32'(ifc.nice_acr_rsp_valid), 32'd1);
        chk("bp_rsp2_err", 32'(ifc.nice_acr_rsp_err), 32'd1);
        chk("bp_errcnt", 32'(err_cnt), 32'(exp_errcnt));
        @(negedge clk);
        wr_ready = 2'b00;

        // RD_LAT=3 instance: rsp expected 6 cycles after accept.
        rd_data = 32'h87654321;
        chk("lat3_ready", 32'(ifc3.nice_acr_cmd_ready), 32'd1);
        ifc3.nice_acr_cmd_valid = 1'b1;
        ifc3.nice_acr_cmd_addr  = 6'd7;
        ifc3.nice_acr_cmd_read  = 1'b1;
        @(negedge clk);
        ifc3.nice_acr_cmd_valid = 1'b0;
        rsp_cyc = 0; rden_cnt = 0;
        for (int c = 2; c < 30 && rsp_cyc == 0; c++) begin
            @(negedge clk);
            if (rd_en3) begin
                rden_cnt++;
                chk("lat3_rd_addr", 32'(rd_addr3), 32'd7);
            end
            if (ifc3.nice_acr_rsp_valid) begin
                rsp_cyc = c;
                chk("lat3_rdata", ifc3.nice_acr_rsp_rdata, 32'h87654321);
            end
        end
        chk("lat3_rden", 32'(rden_cnt), 32'd1);
        chk("lat3_rsp_cyc", 32'(rsp_cyc), 32'd6);
        @(negedge clk);

        // Reset while a write waits in WR.
        chk("rstwr_errcnt_before", 32'(err_cnt), 32'(exp_errcnt));
        wr_ready = 2'b00;
        send(6'd21, 1'b0, 32'h55AA55AA);
        @(negedge clk);
        chk("rstwr_wv", 32'(wr_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstwr_wv0", 32'(wr_valid), 32'd0);
        chk("rstwr_rsp0", 32'(ifc.nice_acr_rsp_valid), 32'd0);
        chk("rstwr_ready0", 32'(ifc.nice_acr_cmd_ready), 32'd0);
        chk("rstwr_errcnt0", 32'(err_cnt), 32'd0);
        @(negedge clk);
        chk("rstwr_ready1", 32'(ifc.nice_acr_cmd_ready), 32'd1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifc.nice_acr_rsp_valid !== 1'b0 || wr_valid !== 2'b00) bad++;
        end
        chk("rstwr_no_rsp", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
